// File: rtl/serial_sub_nbit.sv
// Multi-cycle N-bit subtractor: d = a - b - bin, STEP bits per clock, LSB chunk first,
// with a start/busy/done handshake and unsigned borrow-out / signed overflow flags.
module serial_sub_nbit #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
        $error("serial_sub_nbit: WIDTH must be >= 2 and a multiple of STEP >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh, b_sh, res, res_nxt;
    logic               brw;
    logic [STEP-1:0]    chunk;
    logic [STEP:0]      chain;
    logic               last, load;

    // Bit-serial ripple across one chunk; chain[k] is the borrow into bit k of the chunk.
    always_comb begin
        chain[0] = brw;
        chunk    = '0;
        for (int k = 0; k < STEP; k++) begin
            chunk[k]     = a_sh[k] ^ b_sh[k] ^ chain[k];
            chain[k+1]   = (~a_sh[k] & b_sh[k]) | (~(a_sh[k] ^ b_sh[k]) & chain[k]);
        end
    end

    // The new chunk enters at the top so the LSB chunk ends up at bit 0 after N shifts.
    assign res_nxt = (res >> STEP) | (WIDTH'(chunk) << (WIDTH - STEP));
    assign last    = (cnt == CNT_W'(N - 1));
    assign load    = start && (state == IDLE || state == DONE);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            brw   <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sh <= a;
                b_sh <= b;
                brw  <= bin;
                cnt  <= '0;
                res  <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> STEP;
                b_sh <= b_sh >> STEP;
                brw  <= chain[STEP];
                res  <= res_nxt;
                cnt  <= cnt + CNT_W'(1);
                // Final chunk holds the MSB: its borrow-in and borrow-out give overflow.
                if (last) begin
                    d    <= res_nxt;
                    bout <= chain[STEP];
                    ovf  <= chain[STEP] ^ chain[STEP-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Directed bench for serial_sub_nbit: a STEP=1 and a STEP=4 instance (WIDTH=8) driven
// from a vector table plus hand-written back-to-back, ignored-start and reset sequences.
module tb_serial_sub_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       busy1, done1, bout1, ovf1;
    logic       busy4, done4, bout4, ovf4;
    logic [7:0] d1, d4;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] prev1 = '0, prev4 = '0;

    always #5 clk = ~clk;

    serial_sub_nbit #(.WIDTH(8), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1)
    );

    serial_sub_nbit #(.WIDTH(8), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full operation on the selected instance, checking handshake timing and result.
    task automatic run_op(input bit use4, input vec_t v);
        int  n;
        bit  ok_busy, held;
        logic [7:0] prev;
        n    = use4 ? 2 : 8;
        prev = use4 ? prev4 : prev1;
        @(negedge clk);
        a = v.a; b = v.b; bin = v.bin;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        ok_busy = 1'b1;
        held    = 1'b1;
        for (int k = 0; k < n; k++) begin
            if ((use4 ? busy4 : busy1) !== 1'b1 || (use4 ? done4 : done1) !== 1'b0) ok_busy = 1'b0;
            if ((use4 ? d4 : d1) !== prev) held = 1'b0;
            @(negedge clk);
        end
        check($sformatf("busy_window s%0d a=%h b=%h", use4 ? 4 : 1, v.a, v.b), 32'(ok_busy), 32'd1);
        check($sformatf("d_held s%0d a=%h b=%h", use4 ? 4 : 1, v.a, v.b), 32'(held), 32'd1);
        check($sformatf("done s%0d a=%h b=%h", use4 ? 4 : 1, v.a, v.b), 32'(use4 ? done4 : done1), 32'd1);
        check($sformatf("busy_low s%0d a=%h b=%h", use4 ? 4 : 1, v.a, v.b), 32'(use4 ? busy4 : busy1), 32'd0);
        check($sformatf("d s%0d a=%h b=%h bin=%0d", use4 ? 4 : 1, v.a, v.b, v.bin),
              32'(use4 ? d4 : d1), 32'(v.d));
        check($sformatf("bout s%0d a=%h b=%h bin=%0d", use4 ? 4 : 1, v.a, v.b, v.bin),
              32'(use4 ? bout4 : bout1), 32'(v.bout));
        check($sformatf("ovf s%0d a=%h b=%h bin=%0d", use4 ? 4 : 1, v.a, v.b, v.bin),
              32'(use4 ? ovf4 : ovf1), 32'(v.ovf));
        if (use4) prev4 = v.d; else prev1 = v.d;
    endtask

    initial begin
        int   dones;
        logic [7:0] got;

        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hA5, b: 8'h5A, bin: 1'b0, d: 8'h4B, bout: 1'b0, ovf: 1'b1};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 8'h00, b: 8'h80, bin: 1'b0, d: 8'h80, bout: 1'b1, ovf: 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst done1", 32'(done1), 32'd0);
        check("rst d1", 32'(d1), 32'd0);
        check("rst bout1", 32'(bout1), 32'd0);
        check("rst ovf1", 32'(ovf1), 32'd0);
        check("rst busy4", 32'(busy4), 32'd0);
        check("rst d4", 32'(d4), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i]);
            run_op(1'b1, vecs[i]);
        end

        // Back-to-back start in DONE on the STEP=4 instance.
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; bin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b first done", 32'(done4), 32'd1);
        check("b2b first d", 32'(d4), 32'h4B);
        a = 8'h10; b = 8'h01; bin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("b2b direct run busy", 32'(busy4), 32'd1);
        check("b2b direct run done", 32'(done4), 32'd0);
        repeat (2) @(negedge clk);
        check("b2b second done", 32'(done4), 32'd1);
        check("b2b second d", 32'(d4), 32'h0F);
        check("b2b second bout", 32'(bout4), 32'd0);
        check("b2b second ovf", 32'(ovf4), 32'd0);

        // Start during RUN is ignored.
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        dones = 0;
        got   = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                a = 8'hFF; b = 8'h00; bin = 1'b1; start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            if (done1 === 1'b1) begin
                dones++;
                got = d1;
            end
            @(negedge clk);
        end
        check("ignored start done count", 32'(dones), 32'd1);
        check("ignored start d", 32'(got), 32'h02);
        check("ignored start d held", 32'(d1), 32'h02);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 8'h03; b = 8'h05; bin = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst d1", 32'(d1), 32'd0);
        check("async rst bout1", 32'(bout1), 32'd0);
        check("async rst ovf1", 32'(ovf1), 32'd0);
        check("async rst busy1", 32'(busy1), 32'd0);
        check("async rst done1", 32'(done1), 32'd0);
        check("async rst d4", 32'(d4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (done1 === 1'b1) dones++;
            @(negedge clk);
        end
        check("aborted op no done", 32'(dones), 32'd0);
        prev1 = '0;
        prev4 = '0;
        run_op(1'b0, vecs[0]);
        run_op(1'b1, vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
